// File: rtl/hdp_frame_receiver.sv
// rtl/hdp_frame_receiver.sv - HDP link receiver: frame/line/packet recovery, frame counting, sticky framing errors
module hdp_frame_receiver #(
  parameter int PACKETS_PER_LINE = 40,
  parameter int BLANK_PER_LINE   = 4,
  parameter int LINES            = 1280,
  parameter int BACK_PORCH       = 24,
  parameter int UPDATE_LEN       = 28
) (
  input  logic        i_clock,
  input  logic        i_nReset,
  input  logic [31:0] i_lcdData,
  input  logic        i_valid,
  input  logic        i_update,
  input  logic        i_sync,
  input  logic        i_clearErrors,
  output logic [31:0] o_pixelData,
  output logic        o_pixelValid,
  output logic [15:0] o_lineIndex,
  output logic [7:0]  o_packetIndex,
  output logic        o_frameStart,
  output logic        o_frameDone,
  output logic [15:0] o_frameCount,
  output logic        o_inFrame,
  output logic [5:0]  o_errors
);

  localparam logic [7:0]  LAST_DATA_POS  = 8'(PACKETS_PER_LINE - 1);
  localparam logic [7:0]  LAST_BLANK_POS = 8'(PACKETS_PER_LINE + BLANK_PER_LINE - 1);
  localparam logic [15:0] LAST_LINE      = 16'(LINES - 1);
  localparam logic [15:0] LAST_BP        = 16'(BACK_PORCH - 1);
  localparam logic [15:0] ULEN           = 16'(UPDATE_LEN);

  typedef enum logic [1:0] {s_IDLE, s_DATA, s_BLANK, s_BACK_PORCH} state_t;

  state_t      state, state_n;
  logic [7:0]  line_pos, pos_n, pix_pos;
  logic [15:0] line_r, line_n, pix_line;
  logic [15:0] bp_cnt, bp_n;
  logic [15:0] upd_cnt, upd_n;
  logic        upd_prev;
  logic        rise_upd, fall_upd;
  logic        present, start, done;
  logic [5:0]  err_set;

  assign rise_upd = i_update & ~upd_prev;
  assign fall_upd = ~i_update & upd_prev;

  // State register
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) state <= s_IDLE;
    else           state <= state_n;
  end

  // Next state, position counters, presentation and error detection for the sampled cycle
  always_comb begin
    state_n  = state;
    pos_n    = line_pos;
    line_n   = line_r;
    bp_n     = bp_cnt;
    upd_n    = upd_cnt;
    pix_line = line_r;
    pix_pos  = line_pos;
    present  = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    err_set  = 6'b0;

    if (i_sync) err_set[5] = 1'b1;

    // Update pulse length is only policed while a frame is running
    if (state != s_IDLE) begin
      if (i_update && upd_prev && upd_cnt <= ULEN) begin
        upd_n = upd_cnt + 16'd1;
        if (upd_cnt == ULEN) err_set[3] = 1'b1;
      end
      if (fall_upd && upd_cnt != ULEN) err_set[3] = 1'b1;
    end

    case (state)
      s_DATA: begin
        present = i_valid;
        if (!i_valid) err_set[0] = 1'b1;
        pos_n = line_pos + 8'd1;
        if (line_pos == LAST_DATA_POS) state_n = s_BLANK;
      end
      s_BLANK: begin
        if (i_valid) err_set[1] = 1'b1;
        if (i_lcdData != 32'd0) err_set[2] = 1'b1;
        if (line_pos == LAST_BLANK_POS) begin
          if (line_r == LAST_LINE) begin
            state_n = s_BACK_PORCH;
            bp_n    = 16'd0;
          end else begin
            line_n  = line_r + 16'd1;
            pos_n   = 8'd0;
            state_n = s_DATA;
          end
        end else begin
          pos_n = line_pos + 8'd1;
        end
      end
      s_BACK_PORCH: begin
        if (bp_cnt == LAST_BP) begin
          state_n = s_IDLE;
          done    = 1'b1;
        end else begin
          bp_n = bp_cnt + 16'd1;
        end
      end
      default: ;
    endcase

    // An update rise always (re)starts a frame; this cycle is line 0 packet 0
    if (rise_upd) begin
      if (state != s_IDLE) err_set[4] = 1'b1;
      err_set[2:0] = {2'b00, ~i_valid};
      done     = 1'b0;
      start    = 1'b1;
      present  = i_valid;
      pix_line = 16'd0;
      pix_pos  = 8'd0;
      line_n   = 16'd0;
      pos_n    = 8'd1;
      upd_n    = 16'd1;
      state_n  = (PACKETS_PER_LINE > 1) ? s_DATA : s_BLANK;
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      line_pos      <= 8'd0;
      line_r        <= 16'd0;
      bp_cnt        <= 16'd0;
      upd_cnt       <= 16'd0;
      upd_prev      <= 1'b0;
      o_pixelData   <= 32'd0;
      o_pixelValid  <= 1'b0;
      o_lineIndex   <= 16'd0;
      o_packetIndex <= 8'd0;
      o_frameStart  <= 1'b0;
      o_frameDone   <= 1'b0;
      o_frameCount  <= 16'd0;
      o_inFrame     <= 1'b0;
      o_errors      <= 6'd0;
    end else begin
      line_pos     <= pos_n;
      line_r       <= line_n;
      bp_cnt       <= bp_n;
      upd_cnt      <= upd_n;
      upd_prev     <= i_update;
      o_pixelValid <= present;
      if (present) begin
        o_pixelData   <= i_lcdData;
        o_lineIndex   <= pix_line;
        o_packetIndex <= pix_pos;
      end
      o_frameStart <= start;
      o_frameDone  <= done;
      if (done) o_frameCount <= o_frameCount + 16'd1;
      o_inFrame    <= (state_n != s_IDLE);
      o_errors     <= i_clearErrors ? 6'd0 : (o_errors | err_set);
    end
  end

endmodule

// File: tb/tb_hdp_frame_receiver.sv
// tb/tb_hdp_frame_receiver.sv - directed self-checking bench for hdp_frame_receiver
module tb_hdp_frame_receiver;

  localparam int PPL  = 4;
  localparam int BLK  = 2;
  localparam int LN   = 3;
  localparam int BP   = 5;
  localparam int ULEN = 3;

  logic        clk = 1'b0;
  logic        i_nReset = 1'b0;
  logic [31:0] i_lcdData = '0;
  logic        i_valid = 1'b0;
  logic        i_update = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_clearErrors = 1'b0;
  logic [31:0] o_pixelData;
  logic        o_pixelValid;
  logic [15:0] o_lineIndex;
  logic [7:0]  o_packetIndex;
  logic        o_frameStart;
  logic        o_frameDone;
  logic [15:0] o_frameCount;
  logic        o_inFrame;
  logic [5:0]  o_errors;

  int checks = 0;
  int errors = 0;

  hdp_frame_receiver #(
    .PACKETS_PER_LINE(PPL), .BLANK_PER_LINE(BLK), .LINES(LN),
    .BACK_PORCH(BP), .UPDATE_LEN(ULEN)
  ) dut (
    .i_clock(clk), .i_nReset(i_nReset), .i_lcdData(i_lcdData), .i_valid(i_valid),
    .i_update(i_update), .i_sync(i_sync), .i_clearErrors(i_clearErrors),
    .o_pixelData(o_pixelData), .o_pixelValid(o_pixelValid), .o_lineIndex(o_lineIndex),
    .o_packetIndex(o_packetIndex), .o_frameStart(o_frameStart), .o_frameDone(o_frameDone),
    .o_frameCount(o_frameCount), .o_inFrame(o_inFrame), .o_errors(o_errors)
  );

  always #5 clk = ~clk;

  task automatic step(input logic upd, input logic vld, input logic [31:0] d);
    i_update  = upd;
    i_valid   = vld;
    i_lcdData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    i_nReset = 1'b0; i_update = 1'b0; i_valid = 1'b0; i_lcdData = '0;
    i_sync = 1'b0; i_clearErrors = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_nReset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int upd_len, input int drop_l, input int drop_p,
                           input int bad_l, input int restart_l,
                           output int pix, output int fs, output int fc_restart);
    int l, p, cyc, ul;
    bit restarted;
    logic vld, exp_v;
    logic [31:0] d;
    pix = 0; fs = 0; fc_restart = -1; restarted = 0; cyc = 0; ul = upd_len; l = 0;
    while (l < LN) begin
      p = 0;
      while (p < PPL + BLK) begin
        if (!restarted && l == restart_l && p == 0) begin
          restarted = 1; l = 0; cyc = 0; ul = ULEN;
        end
        vld = (p < PPL);
        d   = (p < PPL) ? 32'(l * 16 + p) : 32'd0;
        if (l == drop_l && p == drop_p) vld = 1'b0;
        if (l == bad_l && p == PPL) begin vld = 1'b1; d = 32'hDEADBEEF; end
        step(cyc < ul, vld, d);
        cyc++;
        exp_v = (p < PPL) && vld;
        checks++;
        if (o_pixelValid !== exp_v) begin
          errors++;
          $display("FAIL pixel_valid l=%0d p=%0d got %b want %b", l, p, o_pixelValid, exp_v);
        end
        if (exp_v) begin
          checks++;
          if (o_pixelData !== 32'(l * 16 + p) || o_lineIndex !== 16'(l) || o_packetIndex !== 8'(p)) begin
            errors++;
            $display("FAIL pixel l=%0d p=%0d got data=%h line=%0d pkt=%0d", l, p, o_pixelData, o_lineIndex, o_packetIndex);
          end
        end
        checks++;
        if (o_frameStart !== (l == 0 && p == 0) || o_frameDone !== 1'b0 || o_inFrame !== 1'b1) begin
          errors++;
          $display("FAIL frame_flags l=%0d p=%0d got start=%b done=%b in=%b", l, p, o_frameStart, o_frameDone, o_inFrame);
        end
        if (restarted && l == 0 && p == 0) fc_restart = int'(o_frameCount);
        pix += int'(o_pixelValid);
        fs  += int'(o_frameStart);
        p++;
      end
      l++;
    end
    for (int b = 0; b < BP; b++) begin
      step(1'b0, 1'b1, 32'hFFFF_FFFF);
      checks++;
      if (o_frameDone !== (b == BP - 1) || o_inFrame !== (b != BP - 1) || o_pixelValid !== 1'b0) begin
        errors++;
        $display("FAIL back_porch b=%0d got done=%b in=%b valid=%b", b, o_frameDone, o_inFrame, o_pixelValid);
      end
    end
  endtask

  task automatic test_reset;
    i_nReset = 1'b0;
    #3;
    checks++;
    if ({o_pixelData, o_pixelValid, o_lineIndex, o_packetIndex, o_frameStart,
         o_frameDone, o_frameCount, o_inFrame, o_errors} !== '0) begin
      errors++;
      $display("FAIL reset_state got data=%h cnt=%0d err=%b in=%b", o_pixelData, o_frameCount, o_errors, o_inFrame);
    end
    apply_reset();
  endtask

  task automatic test_nominal;
    int pix, fs, fcr;
    apply_reset();
    run_frame(ULEN, -1, -1, -1, -1, pix, fs, fcr);
    checks++;
    if (pix != 12 || fs != 1) begin errors++; $display("FAIL nominal_counts got pix=%0d fs=%0d want 12 1", pix, fs); end
    checks++;
    if (o_frameCount !== 16'd1 || o_errors !== 6'd0) begin
      errors++; $display("FAIL nominal_status got cnt=%0d err=%b want 1 0", o_frameCount, o_errors);
    end
  endtask

  task automatic test_back_to_back;
    int pix, fs, fcr;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(ULEN, -1, -1, -1, -1, pix, fs, fcr);
      checks++;
      if (pix != 12 || fs != 1 || o_frameCount !== 16'(f + 1)) begin
        errors++; $display("FAIL b2b_frame%0d got pix=%0d fs=%0d cnt=%0d", f, pix, fs, o_frameCount);
      end
    end
    checks++;
    if (o_frameCount !== 16'd3 || o_errors !== 6'd0) begin
      errors++; $display("FAIL b2b_status got cnt=%0d err=%b want 3 0", o_frameCount, o_errors);
    end
  endtask

  task automatic test_valid_drop;
    int pix, fs, fcr;
    apply_reset();
    run_frame(ULEN, 1, 2, -1, -1, pix, fs, fcr);
    checks++;
    if (pix != 11 || o_errors !== 6'b000001 || o_frameCount !== 16'd1) begin
      errors++; $display("FAIL valid_drop got pix=%0d err=%b cnt=%0d want 11 000001 1", pix, o_errors, o_frameCount);
    end
  endtask

  task automatic test_blank_violation;
    int pix, fs, fcr;
    apply_reset();
    run_frame(ULEN, -1, -1, 0, -1, pix, fs, fcr);
    checks++;
    if (pix != 12 || o_errors !== 6'b000110) begin
      errors++; $display("FAIL blank_violation got pix=%0d err=%b want 12 000110", pix, o_errors);
    end
  endtask

  task automatic test_update_faults;
    int pix, fs, fcr;
    apply_reset();
    run_frame(ULEN + 1, -1, -1, -1, 2, pix, fs, fcr);
    checks++;
    if (fs != 2 || fcr != 0 || pix != 20) begin
      errors++; $display("FAIL update_restart got fs=%0d cnt_at_restart=%0d pix=%0d want 2 0 20", fs, fcr, pix);
    end
    checks++;
    if (o_errors !== 6'b011000 || o_frameCount !== 16'd1) begin
      errors++; $display("FAIL update_faults got err=%b cnt=%0d want 011000 1", o_errors, o_frameCount);
    end
  endtask

  task automatic test_reset_midframe;
    int pix, fs, fcr;
    apply_reset();
    for (int s = 0; s < PPL + BLK + 2; s++) begin
      step(s < ULEN, (s % (PPL + BLK)) < PPL, 32'(s));
    end
    i_nReset = 1'b0;
    #2;
    checks++;
    if ({o_pixelData, o_pixelValid, o_lineIndex, o_packetIndex, o_frameStart,
         o_frameDone, o_frameCount, o_inFrame, o_errors} !== '0) begin
      errors++;
      $display("FAIL midframe_reset got valid=%b line=%0d pkt=%0d in=%b", o_pixelValid, o_lineIndex, o_packetIndex, o_inFrame);
    end
    i_nReset = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    run_frame(ULEN, -1, -1, -1, -1, pix, fs, fcr);
    checks++;
    if (pix != 12 || fs != 1 || o_frameCount !== 16'd1 || o_errors !== 6'd0) begin
      errors++; $display("FAIL post_reset_frame got pix=%0d fs=%0d cnt=%0d err=%b", pix, fs, o_frameCount, o_errors);
    end
  endtask

  task automatic test_clear;
    apply_reset();
    i_sync = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_errors !== 6'b100000) begin errors++; $display("FAIL sync_seen got %b want 100000", o_errors); end
    i_clearErrors = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_errors !== 6'd0) begin errors++; $display("FAIL clear_priority got %b want 000000", o_errors); end
    i_clearErrors = 1'b0;
    i_sync = 1'b0;
    step(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_errors !== 6'd0) begin errors++; $display("FAIL clear_lost got %b want 000000", o_errors); end
    i_sync = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    i_sync = 1'b0;
    i_clearErrors = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    i_clearErrors = 1'b0;
    checks++;
    if (o_errors !== 6'd0) begin errors++; $display("FAIL clear_pulse got %b want 000000", o_errors); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_valid_drop();
    test_blank_violation();
    test_update_faults();
    test_reset_midframe();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdp_frame_receiver.md
Name: hdp_frame_receiver

Overview:
- Panel-side receiver for the 32-bit HDP stream produced by the LCD driver (data, valid, update, sync).
- Recovers frame, line and packet framing; re-presents valid packets with their coordinates; counts completed frames.
- Flags framing violations in sticky error bits.
- Used as the loopback and monitor end of the HDP link, both on-board and in simulation.

Parameters:
- PACKETS_PER_LINE, 40, valid 32-bit packets per line (1280 px / 32).
- BLANK_PER_LINE, 4, blank clocks per line; valid must be low and data zero.
- LINES, 1280, lines per frame.
- BACK_PORCH, 24, clocks after the last line's blanking; inputs ignored except update.
- UPDATE_LEN, 28, required high length of update at frame start, in clocks.

Ports:
- i_clock  in  1  link clock; all inputs sampled on its rising edge (the transmitter launches on the falling edge).
- i_nReset  in  1  asynchronous, active-low reset.
- i_lcdData  in  32  HDP data.
- i_valid  in  1  HDP data valid.
- i_update  in  1  HDP update; a rising edge marks packet 0 of line 0.
- i_sync  in  1  HDP sync; must stay 0, otherwise it is an error.
- i_clearErrors  in  1  synchronous clear of all sticky error bits.
- o_pixelData  out  32  captured packet.
- o_pixelValid  out  1  o_pixelData/o_lineIndex/o_packetIndex valid this cycle.
- o_lineIndex  out  16  line of the presented packet, 0..LINES-1.
- o_packetIndex  out  8  packet within the line, 0..PACKETS_PER_LINE-1.
- o_frameStart  out  1  one-cycle pulse, coincident with packet 0 of line 0 on the outputs.
- o_frameDone  out  1  one-cycle pulse after the last back-porch clock.
- o_frameCount  out  16  completed frames; wraps 0xFFFF->0.
- o_inFrame  out  1  high whenever state != s_IDLE.
- o_errors  out  6  sticky: [0] validDrop, [1] validExtra, [2] blankData, [3] updateLen, [4] earlyUpdate, [5] syncSeen.

Behaviour:
- Reset (async, i_nReset=0): state s_IDLE; all counters, outputs and error bits 0; previous-update register 0.
- Update edge: riseUpd = i_update & ~updPrev; updPrev is registered every cycle.
- All outputs are registered. The packet sampled in cycle N appears on the outputs in cycle N+1 (latency 1).
- s_IDLE: on riseUpd, treat the cycle as line 0 packet 0.
  - Capture data; pulse o_frameStart next cycle.
  - Set linePos=1, line=0, updCnt=1; go to s_DATA.
- s_DATA (linePos < PACKETS_PER_LINE):
  - i_valid=1: present the packet with its line and linePos.
  - i_valid=0: o_pixelValid=0, set validDrop; the position still advances.
  - After position PACKETS_PER_LINE-1, go to s_BLANK.
- s_BLANK:
  - i_valid=1 sets validExtra; i_lcdData != 0 sets blankData; nothing is presented.
  - At the last blank position, if line==LINES-1 go to s_BACK_PORCH with bpCnt=0; else line+1, linePos=0, go to s_DATA.
- s_BACK_PORCH:
  - Count BACK_PORCH clocks; i_valid and i_lcdData are ignored.
  - On the final clock: go to s_IDLE, pulse o_frameDone next cycle, o_frameCount+1.
  - A riseUpd in the cycle immediately after the final clock is a normal frame start, with no error.
- Update length, checked in any non-idle state:
  - updCnt counts consecutive high cycles from the frame start.
  - On the falling edge, updCnt != UPDATE_LEN sets updateLen.
  - updCnt reaching UPDATE_LEN+1 also sets updateLen; counting then saturates.
- Early update: riseUpd in s_DATA, s_BLANK or s_BACK_PORCH sets earlyUpdate and restarts the frame exactly as from s_IDLE.
  - o_frameStart pulses; o_frameCount does not change.
- i_sync=1 in any cycle sets syncSeen.
- Simultaneous events: multiple error bits may set in the same cycle. i_clearErrors has priority over setting only for that cycle; errors detected in the same cycle are lost.
- Width rules: linePos is 8 bits and line 16 bits, so PACKETS_PER_LINE+BLANK_PER_LINE <= 256 and LINES <= 65536. Index outputs are zero-extended.

Test Plan (sim parameters: PACKETS_PER_LINE=4, BLANK_PER_LINE=2, LINES=3, BACK_PORCH=5, UPDATE_LEN=3):
- Nominal frame:
  - Stimulus: update high 3 clocks; data = line*16+packet on valid slots, zeros on blank slots.
  - Required: 12 o_pixelValid pulses with matching data and indices; o_frameStart once; o_frameDone 1 cycle after the 5th back-porch clock; o_frameCount=1; o_errors=0.
- Back-to-back frames:
  - Stimulus: three frames with no gap after the back porch.
  - Required: o_frameCount=3; o_errors=0; no missing or duplicated o_frameStart.
- Valid drop:
  - Stimulus: i_valid=0 at line 1 packet 2.
  - Required: errors[0]=1; 11 pixels presented; o_frameCount still increments.
- Blank violations:
  - Stimulus: i_valid=1 and data 0xDEADBEEF in a blank slot of line 0.
  - Required: errors[1]=1 and errors[2]=1; no pixel presented for that slot.
- Update faults:
  - Stimulus: update high 4 clocks, then a new update rise at line 2 packet 0.
  - Required: errors[3]=1; errors[4]=1; o_frameStart pulses again; o_frameCount=0; the frame completes after the restart.
- Reset and clear:
  - Stimulus: i_nReset low at line 1 packet 1.
  - Required: outputs 0 immediately and o_inFrame=0; the next update rise starts a clean frame.
  - Stimulus: i_clearErrors pulse with errors set.
  - Required: o_errors=0 on the next cycle.
